// File: rtl/decode_scoreboard_pkg.sv
// Shared encodings for the decode-stage register scoreboard: zero register,
// forwarding-select values, pipeline stage indices and result latency classes.
package decode_scoreboard_pkg;

   localparam int ZERO_REG = 0;

   // Forwarding select 0 means "read the register file"; k selects stage k.
   localparam int FWD_RF  = 0;
   localparam int STG_EX  = 1;
   localparam int STG_MEM = 2;
   localparam int STG_WB  = 3;

   localparam int LAT_ALU  = 0;
   localparam int LAT_LOAD = 1;
   localparam int LAT_MUL  = 2;

endpackage

// File: rtl/decode_scoreboard_entry.sv
// One architectural register's youngest in-flight producer: where it sits in
// the pipeline (stage) and how many more cycles until its result is forwardable.
module decode_scoreboard_entry
   import decode_scoreboard_pkg::*;
#(
   parameter int NUM_STAGES = 3,
   parameter int LAT_W      = 2,
   parameter int SEL_W      = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             hold_i,
   input  logic             flush_i,
   input  logic             load_i,
   input  logic [LAT_W-1:0] lat_i,
   output logic             inflight_o,
   output logic [SEL_W-1:0] stage_o,
   output logic [LAT_W-1:0] busy_o
);

   logic             inflight_q, inflight_d;
   logic [SEL_W-1:0] stage_q, stage_d;
   logic [LAT_W-1:0] busy_q, busy_d;

   function automatic logic [LAT_W-1:0] sat_dec(input logic [LAT_W-1:0] v);
      return (v == '0) ? '0 : v - LAT_W'(1);
   endfunction

   always_comb begin
      inflight_d = inflight_q;
      stage_d    = stage_q;
      busy_d     = busy_q;
      if (flush_i) begin
         inflight_d = 1'b0;
         stage_d    = '0;
         busy_d     = '0;
      end else if (!hold_i) begin
         if (inflight_q) begin
            // Leaving the last stage means the value has reached the RF.
            if (stage_q == SEL_W'(NUM_STAGES)) begin
               inflight_d = 1'b0;
               stage_d    = '0;
               busy_d     = '0;
            end else begin
               stage_d = stage_q + SEL_W'(1);
               busy_d  = sat_dec(busy_q);
            end
         end
         if (load_i) begin
            inflight_d = 1'b1;
            stage_d    = SEL_W'(STG_EX);
            busy_d     = lat_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) inflight_q <= 1'b0;
      else        inflight_q <= inflight_d;
   end

   // stage/busy are only observed while inflight is set.
   always_ff @(posedge clk) begin
      stage_q <= stage_d;
      busy_q  <= busy_d;
   end

   assign inflight_o = inflight_q;
   assign stage_o    = stage_q;
   assign busy_o     = busy_q;

endmodule

// File: rtl/decode_scoreboard.sv
// ID-stage register hazard scoreboard: per-source forwarding selects, load-use
// and write-after-write stalls across NUM_STAGES producer stages.
module decode_scoreboard
   import decode_scoreboard_pkg::*;
#(
   parameter int NUM_REGS   = 32,
   parameter int ADDR_W     = 5,
   parameter int NUM_STAGES = 3,
   parameter int LAT_W      = 2,
   parameter int SEL_W      = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                hold,
   input  logic                flush,
   input  logic                issue_valid,
   input  logic                issue_we,
   input  logic [ADDR_W-1:0]   issue_dst,
   input  logic [LAT_W-1:0]    issue_lat,
   input  logic [ADDR_W-1:0]   rs_addr,
   input  logic                rs_used,
   input  logic [ADDR_W-1:0]   rt_addr,
   input  logic                rt_used,
   output logic                stall,
   output logic [SEL_W-1:0]    rs_fwd_sel,
   output logic [SEL_W-1:0]    rt_fwd_sel,
   output logic [NUM_REGS-1:0] pending_mask
);

   localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(NUM_STAGES - 1);

   logic [NUM_REGS-1:0] inflight;
   logic [SEL_W-1:0]    stage [NUM_REGS];
   logic [LAT_W-1:0]    busy  [NUM_REGS];

   logic [LAT_W-1:0] lat_c;
   logic             accept;
   logic             rs_hz, rt_hz, rs_busy, rt_busy, waw;

   assign lat_c = (issue_lat > LAT_MAX) ? LAT_MAX : issue_lat;

   assign inflight[0] = 1'b0;
   assign stage[0]    = '0;
   assign busy[0]     = '0;

   for (genvar g = 1; g < NUM_REGS; g++) begin : g_entry
      decode_scoreboard_entry #(
         .NUM_STAGES(NUM_STAGES),
         .LAT_W     (LAT_W),
         .SEL_W     (SEL_W)
      ) u_entry (
         .clk       (clk),
         .rst_n     (rst_n),
         .hold_i    (hold),
         .flush_i   (flush),
         .load_i    (accept && issue_we && (issue_dst == ADDR_W'(g))),
         .lat_i     (lat_c),
         .inflight_o(inflight[g]),
         .stage_o   (stage[g]),
         .busy_o    (busy[g])
      );
   end

   always_comb begin
      rs_hz   = rs_used && (rs_addr != ADDR_W'(ZERO_REG)) && inflight[rs_addr];
      rt_hz   = rt_used && (rt_addr != ADDR_W'(ZERO_REG)) && inflight[rt_addr];
      rs_busy = rs_hz && (busy[rs_addr] != '0);
      rt_busy = rt_hz && (busy[rt_addr] != '0);

      rs_fwd_sel = (rs_hz && !rs_busy) ? stage[rs_addr] : SEL_W'(FWD_RF);
      rt_fwd_sel = (rt_hz && !rt_busy) ? stage[rt_addr] : SEL_W'(FWD_RF);

      // A faster younger write must not land before a slower older one.
      waw = issue_we && (issue_dst != ADDR_W'(ZERO_REG)) && inflight[issue_dst]
            && (lat_c < busy[issue_dst]);

      stall = issue_valid && (rs_busy || rt_busy || waw);
   end

   assign accept       = issue_valid && !stall && !hold && !flush;
   assign pending_mask = inflight;

   a_lat_legal : assert property (@(posedge clk) disable iff (!rst_n)
      !(issue_valid && issue_we && (issue_lat > LAT_MAX)));

endmodule

// File: tb/tb_decode_scoreboard.sv
// Directed table-driven bench for decode_scoreboard plus hand-built sequences
// for hold/flush, write-after-write ordering, mid-run reset and register zero.
module tb_decode_scoreboard;
   import decode_scoreboard_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, hold, flush, issue_valid, issue_we, rs_used, rt_used;
   logic [4:0]  issue_dst, rs_addr, rt_addr;
   logic [1:0]  issue_lat;
   logic        stall;
   logic [1:0]  rs_fwd_sel, rt_fwd_sel;
   logic [31:0] pending_mask;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        rst_n, hold, flush, iv, we;
      logic [4:0]  dst;
      logic [1:0]  lat;
      logic [4:0]  rs;
      logic        rsu;
      logic [4:0]  rt;
      logic        rtu;
      logic        e_stall;
      logic [1:0]  e_rs, e_rt;
      logic [31:0] e_pend;
   } vec_t;

   vec_t vecs[$];

   decode_scoreboard dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .hold        (hold),
      .flush       (flush),
      .issue_valid (issue_valid),
      .issue_we    (issue_we),
      .issue_dst   (issue_dst),
      .issue_lat   (issue_lat),
      .rs_addr     (rs_addr),
      .rs_used     (rs_used),
      .rt_addr     (rt_addr),
      .rt_used     (rt_used),
      .stall       (stall),
      .rs_fwd_sel  (rs_fwd_sel),
      .rt_fwd_sel  (rt_fwd_sel),
      .pending_mask(pending_mask)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] bm(input int n);
      return 32'd1 << n;
   endfunction

   function automatic vec_t mk(input int r, h, f, iv, we, dst, lat, rs, rsu, rt, rtu,
                               es, ers, ert, input logic [31:0] ep);
      vec_t v;
      v.rst_n = 1'(r);   v.hold = 1'(h);  v.flush = 1'(f);
      v.iv = 1'(iv);     v.we = 1'(we);   v.dst = 5'(dst);  v.lat = 2'(lat);
      v.rs = 5'(rs);     v.rsu = 1'(rsu); v.rt = 5'(rt);    v.rtu = 1'(rtu);
      v.e_stall = 1'(es); v.e_rs = 2'(ers); v.e_rt = 2'(ert); v.e_pend = ep;
      return v;
   endfunction

   task automatic cmp(input string name, input int row, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row=%0d got=%0h expected=%0h", name, row, act, exp);
      end
   endtask

   // Drive one cycle's inputs, check outputs mid-cycle, then cross the edge.
   task automatic apply(input vec_t v, input int row);
      rst_n = v.rst_n; hold = v.hold; flush = v.flush;
      issue_valid = v.iv; issue_we = v.we; issue_dst = v.dst; issue_lat = v.lat;
      rs_addr = v.rs; rs_used = v.rsu; rt_addr = v.rt; rt_used = v.rtu;
      @(negedge clk);
      cmp("stall", row, 32'(stall), 32'(v.e_stall));
      cmp("rs_fwd_sel", row, 32'(rs_fwd_sel), 32'(v.e_rs));
      cmp("rt_fwd_sel", row, 32'(rt_fwd_sel), 32'(v.e_rt));
      cmp("pending_mask", row, pending_mask, v.e_pend);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; hold = 1'b0; flush = 1'b0; issue_valid = 1'b0; issue_we = 1'b0;
      issue_dst = '0; issue_lat = '0; rs_addr = '0; rs_used = 1'b0;
      rt_addr = '0; rt_used = 1'b0;

      //            r h f iv we dst lat       rs rsu rt rtu  st rs rt pend
      // reset while issuing dst=5
      vecs.push_back(mk(0,0,0,1,1, 5,LAT_ALU,  0,0, 0,0,  0,0,0, 32'd0));
      vecs.push_back(mk(0,0,0,1,1, 5,LAT_ALU,  0,0, 0,0,  0,0,0, 32'd0));
      vecs.push_back(mk(1,0,0,0,0, 0,0,        0,0, 0,0,  0,0,0, 32'd0));
      // ALU back-to-back
      vecs.push_back(mk(1,0,0,1,1, 8,LAT_ALU,  0,0, 0,0,  0,0,0, 32'd0));
      vecs.push_back(mk(1,0,0,1,0, 0,0,        8,1, 0,0,  0,STG_EX,0,  bm(8)));
      vecs.push_back(mk(1,0,0,1,0, 0,0,        8,1, 0,0,  0,STG_MEM,0, bm(8)));
      vecs.push_back(mk(1,0,0,1,0, 0,0,        8,1, 0,0,  0,STG_WB,0,  bm(8)));
      vecs.push_back(mk(1,0,0,1,0, 0,0,        8,1, 0,0,  0,FWD_RF,0,  32'd0));
      // load-use
      vecs.push_back(mk(1,0,0,1,1, 9,LAT_LOAD, 0,0, 0,0,  0,0,0, 32'd0));
      vecs.push_back(mk(1,0,0,1,0, 0,0,        0,0, 9,1,  1,0,0, bm(9)));
      vecs.push_back(mk(1,0,0,1,0, 0,0,        0,0, 9,1,  0,0,STG_MEM, bm(9)));
      vecs.push_back(mk(1,0,0,0,0, 0,0,        0,0, 0,0,  0,0,0, bm(9)));
      vecs.push_back(mk(1,0,0,0,0, 0,0,        0,0, 0,0,  0,0,0, 32'd0));
      // load followed by an instruction that does not read rt
      vecs.push_back(mk(1,0,0,1,1, 9,LAT_LOAD, 0,0, 0,0,  0,0,0, 32'd0));
      vecs.push_back(mk(1,0,0,1,0, 0,0,        0,0, 9,0,  0,0,0, bm(9)));
      vecs.push_back(mk(1,0,0,0,0, 0,0,        0,0, 0,0,  0,0,0, bm(9)));
      vecs.push_back(mk(1,0,0,0,0, 0,0,        0,0, 0,0,  0,0,0, bm(9)));
      vecs.push_back(mk(1,0,0,0,0, 0,0,        0,0, 0,0,  0,0,0, 32'd0));

      @(posedge clk);
      #1;
      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

      // MUL in flight, frozen by hold for three cycles, then flushed under hold
      apply(mk(1,0,0,1,1, 10,LAT_MUL, 0,0, 0,0,  0,0,0, 32'd0),  100);
      apply(mk(1,1,0,1,0, 0,0,       10,1, 0,0,  1,0,0, bm(10)), 101);
      apply(mk(1,1,0,1,0, 0,0,       10,1, 0,0,  1,0,0, bm(10)), 102);
      apply(mk(1,1,0,1,0, 0,0,       10,1, 0,0,  1,0,0, bm(10)), 103);
      apply(mk(1,1,1,1,0, 0,0,       10,1, 0,0,  1,0,0, bm(10)), 104);
      apply(mk(1,0,0,1,0, 0,0,       10,1, 0,0,  0,0,0, 32'd0),  105);
      // MUL without hold: stalls two cycles then forwards from WB
      apply(mk(1,0,0,1,1, 10,LAT_MUL, 0,0, 0,0,  0,0,0, 32'd0),  106);
      apply(mk(1,0,0,1,0, 0,0,       10,1, 0,0,  1,0,0, bm(10)), 107);
      apply(mk(1,0,0,1,0, 0,0,       10,1, 0,0,  1,0,0, bm(10)), 108);
      apply(mk(1,0,0,1,0, 0,0,       10,1, 0,0,  0,STG_WB,0, bm(10)), 109);
      apply(mk(1,0,0,0,0, 0,0,        0,0, 0,0,  0,0,0, 32'd0),  110);

      // WAW: slow producer then fast producer of the same register
      apply(mk(1,0,0,1,1, 4,LAT_MUL,  0,0, 0,0,  0,0,0, 32'd0), 200);
      apply(mk(1,0,0,1,1, 4,LAT_ALU,  0,0, 0,0,  1,0,0, bm(4)), 201);
      apply(mk(1,0,0,1,1, 4,LAT_ALU,  0,0, 0,0,  1,0,0, bm(4)), 202);
      apply(mk(1,0,0,1,1, 4,LAT_ALU,  0,0, 0,0,  0,0,0, bm(4)), 203);
      apply(mk(1,0,0,1,0, 0,0,        4,1, 4,1,  0,STG_EX,STG_EX,   bm(4)), 204);
      apply(mk(1,0,0,1,0, 0,0,        4,1, 4,1,  0,STG_MEM,STG_MEM, bm(4)), 205);
      apply(mk(1,0,0,1,0, 0,0,        4,1, 4,1,  0,STG_WB,STG_WB,   bm(4)), 206);
      apply(mk(1,0,0,0,0, 0,0,        0,0, 0,0,  0,0,0, 32'd0), 207);
      // younger overwrites while the older is still at MEM
      apply(mk(1,0,0,1,1, 4,LAT_LOAD, 0,0, 0,0,  0,0,0, 32'd0), 210);
      apply(mk(1,0,0,1,1, 4,LAT_ALU,  0,0, 0,0,  1,0,0, bm(4)), 211);
      apply(mk(1,0,0,1,1, 4,LAT_ALU,  0,0, 0,0,  0,0,0, bm(4)), 212);
      apply(mk(1,0,0,1,0, 0,0,        4,1, 0,0,  0,STG_EX,0,  bm(4)), 213);
      apply(mk(1,0,0,1,0, 0,0,        4,1, 0,0,  0,STG_MEM,0, bm(4)), 214);
      apply(mk(1,0,0,1,0, 0,0,        4,1, 0,0,  0,STG_WB,0,  bm(4)), 215);
      apply(mk(1,0,0,1,0, 0,0,        4,1, 0,0,  0,FWD_RF,0,  32'd0), 216);

      // reset in the middle of a MUL
      apply(mk(1,0,0,1,1, 7,LAT_MUL,  0,0, 0,0,  0,0,0, 32'd0), 300);
      apply(mk(0,0,0,1,0, 0,0,        7,1, 0,0,  1,0,0, bm(7)), 301);
      apply(mk(1,0,0,1,0, 0,0,        7,1, 0,0,  0,0,0, 32'd0), 302);

      // register zero is never tracked
      apply(mk(1,0,0,1,1, 0,LAT_MUL,  0,1, 0,1,  0,0,0, 32'd0), 400);
      apply(mk(1,0,0,1,1, 0,LAT_MUL,  0,1, 0,1,  0,0,0, 32'd0), 401);
      apply(mk(1,0,0,0,0, 0,0,        0,1, 0,1,  0,0,0, 32'd0), 402);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
